// File: rtl/imem_boot_pkg.sv
// ---------------------------------------------------------------------------
// imem_boot_pkg
// Shared definitions for the instruction-memory boot loader: default memory
// geometry and the loader state encoding.
// ---------------------------------------------------------------------------
package imem_boot_pkg;

   // Default instruction memory: 16K words, addressed by a 14-bit word address.
   localparam int IMEM_ADDR_WIDTH = 14;
   localparam int IMEM_SIZE       = 16384;

   // IDLE  : waiting for a start request, core held or running
   // LOAD  : accepting words from the input stream
   // FLUSH : one cycle in which the final word is written to imem
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2
   } boot_state_t;

endpackage : imem_boot_pkg

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
// Streams a block of instruction words into instruction memory while the core
// is held in reset, then releases the core once the whole block is written.
//
// Ports:
//   clk, resetn          clock and asynchronous active-low reset
//   start                one-cycle load request (sampled in IDLE only)
//   base_addr            first word address of the block
//   word_count           number of words in the block
//   abort                cancel the load in progress (sampled in LOAD only)
//   in_valid / in_data   instruction word stream
//   in_ready             loader accepts in_data this cycle
//   boot_iaddr/idata/iwe imem write port (address zero-extended to 32 bits)
//   core_resetn          active-low reset to the fetch pipeline and core
//   busy                 a load is in progress
//   done / error         one-cycle completion / rejection-or-abort pulses
//   csum                 modulo-2^32 sum of the words loaded
// ---------------------------------------------------------------------------
module imem_boot_loader
   import imem_boot_pkg::*;
#(
   parameter int I_ADDRESSWIDTH = IMEM_ADDR_WIDTH,
   parameter int I_SIZE         = IMEM_SIZE
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      start,
   input  logic [I_ADDRESSWIDTH-1:0] base_addr,
   input  logic [I_ADDRESSWIDTH:0]   word_count,
   input  logic                      abort,
   input  logic                      in_valid,
   input  logic [31:0]               in_data,
   output logic                      in_ready,
   output logic [31:0]               boot_iaddr,
   output logic [31:0]               boot_idata,
   output logic                      boot_iwe,
   output logic                      core_resetn,
   output logic                      busy,
   output logic                      done,
   output logic                      error,
   output logic [31:0]               csum
);

   // The range check carries one extra bit so that a huge word_count added to
   // a high base can never wrap back into the legal range.
   localparam int                    LP_CHKW = I_ADDRESSWIDTH + 2;
   localparam logic [LP_CHKW-1:0]    LP_SIZE = LP_CHKW'(I_SIZE);

   boot_state_t                 r_state;
   boot_state_t                 w_state_nxt;
   logic [I_ADDRESSWIDTH-1:0]   r_base;
   logic [I_ADDRESSWIDTH:0]     r_count;
   logic [I_ADDRESSWIDTH:0]     r_index;
   logic [I_ADDRESSWIDTH-1:0]   r_iaddr;
   logic [31:0]                 r_idata;
   logic                        r_iwe;
   logic [31:0]                 r_csum;
   logic                        r_done;
   logic                        r_error;
   logic                        r_core_resetn;

   logic                        w_accept;
   logic                        w_last;
   logic                        w_range_ok;
   logic                        w_latch;
   logic                        w_done_nxt;
   logic                        w_error_nxt;
   logic                        w_core_resetn_nxt;
   logic [LP_CHKW-1:0]          w_end;

   assign in_ready    = (r_state == ST_LOAD);
   assign busy        = (r_state != ST_IDLE);
   assign w_accept    = in_valid & in_ready;
   assign w_last      = (r_index == (r_count - 1'b1));
   assign w_end       = LP_CHKW'(base_addr) + LP_CHKW'(word_count);
   assign w_range_ok  = (word_count != '0) && (w_end <= LP_SIZE);

   assign boot_iaddr  = 32'(r_iaddr);
   assign boot_idata  = r_idata;
   assign boot_iwe    = r_iwe;
   assign csum        = r_csum;
   assign done        = r_done;
   assign error       = r_error;
   assign core_resetn = r_core_resetn;

   // Next-state and control decode. Abort wins over the last-word transition,
   // but the datapath below still writes a word accepted in the abort cycle.
   // core_resetn only rises when FLUSH retires, after the final write.
   always_comb begin
      w_state_nxt       = r_state;
      w_latch           = 1'b0;
      w_done_nxt        = 1'b0;
      w_error_nxt       = 1'b0;
      w_core_resetn_nxt = r_core_resetn;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (w_range_ok) begin
                  w_state_nxt       = ST_LOAD;
                  w_latch           = 1'b1;
                  w_core_resetn_nxt = 1'b0;
               end else begin
                  w_error_nxt = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            if (abort) begin
               w_state_nxt = ST_IDLE;
               w_error_nxt = 1'b1;
            end else if (w_accept && w_last) begin
               w_state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            w_state_nxt       = ST_IDLE;
            w_done_nxt        = 1'b1;
            w_core_resetn_nxt = 1'b1;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and status pulse registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state       <= ST_IDLE;
         r_done        <= 1'b0;
         r_error       <= 1'b0;
         r_core_resetn <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_done        <= w_done_nxt;
         r_error       <= w_error_nxt;
         r_core_resetn <= w_core_resetn_nxt;
      end
   end

   // Load datapath: block parameters are captured on an accepted start; each
   // accepted word becomes a registered imem write one cycle later and is
   // folded into the running checksum.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_base  <= '0;
         r_count <= '0;
         r_index <= '0;
         r_iaddr <= '0;
         r_idata <= '0;
         r_iwe   <= 1'b0;
         r_csum  <= '0;
      end else begin
         r_iwe <= w_accept;
         if (w_latch) begin
            r_base  <= base_addr;
            r_count <= word_count;
            r_index <= '0;
            r_csum  <= '0;
         end else if (w_accept) begin
            r_iaddr <= r_base + r_index[I_ADDRESSWIDTH-1:0];
            r_idata <= in_data;
            r_csum  <= r_csum + in_data;
            r_index <= r_index + 1'b1;
         end
      end
   end

endmodule : imem_boot_loader
